// File: rtl/bp_host_io_arbiter_if.sv
// Purpose: bundles the requester-side and host-side cmd/resp channels of the host I/O arbiter.
// Latency: wires only, no storage.
// Backpressure: ready/valid on commands, valid/yumi on responses.
//
// master modport: the environment (requesters plus host device).
// slave modport:  the arbiter itself.
interface bp_host_io_arbiter_if
  #(parameter int num_req_p   = 4,
    parameter int msg_width_p = 576);

    logic [num_req_p*msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]             req_cmd_v_i;
    logic [num_req_p-1:0]             req_cmd_ready_and_o;
    logic [num_req_p*msg_width_p-1:0] req_resp_o;
    logic [num_req_p-1:0]             req_resp_v_o;
    logic [num_req_p-1:0]             req_resp_yumi_i;
    logic [msg_width_p-1:0]           io_cmd_o;
    logic                             io_cmd_v_o;
    logic                             io_cmd_ready_and_i;
    logic [msg_width_p-1:0]           io_resp_i;
    logic                             io_resp_v_i;
    logic                             io_resp_yumi_o;

    modport master (
        output req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
               io_cmd_ready_and_i, io_resp_i, io_resp_v_i,
        input  req_cmd_ready_and_o, req_resp_o, req_resp_v_o,
               io_cmd_o, io_cmd_v_o, io_resp_yumi_o
    );

    modport slave (
        input  req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
               io_cmd_ready_and_i, io_resp_i, io_resp_v_i,
        output req_cmd_ready_and_o, req_resp_o, req_resp_v_o,
               io_cmd_o, io_cmd_v_o, io_resp_yumi_o
    );

endinterface

// File: rtl/bp_host_io_arbiter.sv
// Purpose: shares one host I/O cmd/resp channel among num_req_p requesters; round-robin on
//          commands, in-order tag FIFO steers each response back to its issuer.
// Latency: zero-cycle pass-through on both command and response paths.
// Backpressure: host ready stalls the granted requester only; grant is frozen while stalled;
//               at max_outstanding_p in flight or while draining no grants are made.
//
// Ports: clk_i / reset_i (async, active-high); bus (slave modport) carries requester and
//        host channels; drain_i stops new grants; idle_o = drained with nothing in flight;
//        outstanding_o = commands issued but not yet answered.
// Build option: define BP_HOST_IO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module bp_host_io_arbiter
  #(parameter int num_req_p         = 4,
    parameter int msg_width_p       = 576,
    parameter int max_outstanding_p = 32,
    localparam int cnt_w_lp         = $clog2(max_outstanding_p + 1))
   (input  logic                clk_i,
    input  logic                reset_i,
    bp_host_io_arbiter_if.slave bus,
    input  logic                drain_i,
    output logic                idle_o,
    output logic [cnt_w_lp-1:0] outstanding_o);

    localparam int tag_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, IDLE = 2'd2} state_e;

    state_e                state_q, state_d;
    logic [cnt_w_lp-1:0]   count_q, count_d;
    logic [tag_w_lp-1:0]   rr_ptr;
    logic [tag_w_lp-1:0]   grant, idx;
    logic [tag_w_lp-1:0]   tag_mem [max_outstanding_p];
    logic [ptr_w_lp-1:0]   wr_ptr_q, rd_ptr_q;
    logic                  lock_q;
    logic [tag_w_lp-1:0]   lock_idx_q;
    logic                  run_en, can_issue, cmd_v, cmd_fire;
    logic                  fifo_empty, resp_v, resp_pop;
    logic [tag_w_lp-1:0]   head;
    logic [num_req_p-1:0]  ready_vec, resp_v_vec;

    // The tag FIFO holds exactly one entry per outstanding command, so its
    // occupancy is the outstanding count itself.
    assign fifo_empty = (count_q == '0);
    assign can_issue  = run_en && (count_q < cnt_w_lp'(max_outstanding_p));

    // Grant search from rr_ptr upward with wrap. A command stalled by the host
    // keeps its grant even if a requester nearer rr_ptr raises valid meanwhile.
    always_comb begin
        grant = rr_ptr;
        idx   = '0;
        if (lock_q && bus.req_cmd_v_i[lock_idx_q]) begin
            grant = lock_idx_q;
        end else begin
            // Descending scan: the lowest offset from rr_ptr is written last and wins.
            for (int i = num_req_p - 1; i >= 0; i--) begin
                idx = tag_w_lp'((int'(rr_ptr) + i) % num_req_p);
                if (bus.req_cmd_v_i[idx]) grant = idx;
            end
        end
    end

    // Command path
    assign cmd_v    = !reset_i && can_issue && (|bus.req_cmd_v_i);
    assign cmd_fire = cmd_v && bus.io_cmd_ready_and_i;

    always_comb begin
        ready_vec        = '0;
        ready_vec[grant] = !reset_i && can_issue && bus.io_cmd_ready_and_i;
    end

    assign bus.io_cmd_o            = bus.req_cmd_i[int'(grant)*msg_width_p +: msg_width_p];
    assign bus.io_cmd_v_o          = cmd_v;
    assign bus.req_cmd_ready_and_o = ready_vec;

    // Response path: only the requester named at the FIFO head sees valid,
    // and only its yumi can retire the host response.
    assign head     = tag_mem[rd_ptr_q];
    assign resp_v   = !reset_i && bus.io_resp_v_i && !fifo_empty;
    assign resp_pop = resp_v && bus.req_resp_yumi_i[head];

    always_comb begin
        resp_v_vec       = '0;
        resp_v_vec[head] = resp_v;
    end

    assign bus.req_resp_o     = {num_req_p{bus.io_resp_i}};
    assign bus.req_resp_v_o   = resp_v_vec;
    assign bus.io_resp_yumi_o = resp_pop;

    always_comb begin
        count_d = count_q;
        if (cmd_fire && !resp_pop)      count_d = count_q + 1'b1;
        else if (!cmd_fire && resp_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            count_q    <= count_d;
            lock_q     <= cmd_v && !bus.io_cmd_ready_and_i;
            lock_idx_q <= grant;
            if (cmd_fire)
                wr_ptr_q <= (wr_ptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (resp_pop)
                rd_ptr_q <= (rd_ptr_q == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cmd_fire) tag_mem[wr_ptr_q] <= grant;
    end

`ifdef BP_HOST_IO_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)       rr_ptr <= '0;
        else if (cmd_fire) rr_ptr <= (grant == tag_w_lp'(num_req_p - 1)) ? '0 : grant + 1'b1;
    end
`endif

    // FSM: state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= RUN;
        else         state_q <= state_d;
    end

    // FSM: next state. Idle is entered straight after the last pop so idle_o
    // rises the cycle following that pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_i) state_d = DRAIN;
            DRAIN:   if (!drain_i) state_d = RUN;
                     else if (count_d == '0) state_d = IDLE;
            IDLE:    if (!drain_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run_en = 1'b0;
        idle_o = 1'b0;
        case (state_q)
            RUN:     run_en = 1'b1;
            IDLE:    idle_o = 1'b1;
            default: ;
        endcase
    end

    assign outstanding_o = count_q;

    // A host response with nothing outstanding has no owner; it is never yumi'd.
    always @(posedge clk_i) begin
        if (!reset_i)
            assert (!(bus.io_resp_v_i && fifo_empty))
                else $error("host_io_arbiter: orphan response");
    end

endmodule

// File: tb/tb_bp_host_io_arbiter.sv
// Purpose: directed self-checking bench for bp_host_io_arbiter (4 requesters, 6 outstanding).
// Latency: inputs driven 1ns after the rising edge, outputs checked 1ns later.
// Backpressure: host ready and response valid are driven directly by the stimulus.
module tb_bp_host_io_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       drain;
    logic       idle;
    logic [2:0] outstanding;
    int         checks = 0;
    int         errors = 0;
    int         exp_g [6] = '{0, 1, 2, 3, 0, 1};
    int         exp_h [6] = '{1, 2, 3, 0, 1, 2};

    always #5 clk = ~clk;

    bp_host_io_arbiter_if #(.num_req_p(4), .msg_width_p(16)) bus ();

    bp_host_io_arbiter #(.num_req_p(4), .msg_width_p(16), .max_outstanding_p(6)) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .bus          (bus),
        .drain_i      (drain),
        .idle_o       (idle),
        .outstanding_o(outstanding)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drain = 1'b0;
        bus.req_cmd_i = {16'hC300, 16'hC200, 16'hC100, 16'hC000};
        bus.req_cmd_v_i = 4'b1111;
        bus.req_resp_yumi_i = 4'b0000;
        bus.io_cmd_ready_and_i = 1'b1;
        bus.io_resp_i = 16'hBEEF;
        bus.io_resp_v_i = 1'b0;

        // Outputs quiet during reset even with requests pending
        #2;
        chk("rst_cmd_v", bus.io_cmd_v_o, 0);
        chk("rst_ready", bus.req_cmd_ready_and_o, 0);
        chk("rst_idle", idle, 0);
        chk("rst_outstanding", outstanding, 0);
        cyc();
        rst = 1'b0;

        // Round-robin with all valid, host always ready; sixth fire fills to 6
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_grant", bus.req_cmd_ready_and_o, 32'(1) << exp_g[k]);
            chk("rr_cmd_dat", bus.io_cmd_o, 32'hC000 | (exp_g[k] << 8));
            cyc();
        end
        chk("full_outstanding", outstanding, 6);
        chk("full_cmd_v", bus.io_cmd_v_o, 0);
        chk("full_ready", bus.req_cmd_ready_and_o, 0);

        // Yumi on non-head bits only: ignored
        bus.io_resp_v_i = 1'b1;
        bus.req_resp_yumi_i = 4'b1110;
        #1;
        chk("head_resp_v", bus.req_resp_v_o, 4'b0001);
        chk("nonhead_yumi", bus.io_resp_yumi_o, 0);
        cyc();
        chk("nonhead_no_pop", outstanding, 6);

        // Pop while full: no grant in the same cycle
        bus.req_resp_yumi_i = 4'b0001;
        #1;
        chk("pop_yumi", bus.io_resp_yumi_o, 1);
        chk("pop_resp_dat", bus.req_resp_o[47:32], 16'hBEEF);
        chk("pop_same_cycle_cmd_v", bus.io_cmd_v_o, 0);
        cyc();
        bus.io_resp_v_i = 1'b0;
        bus.req_resp_yumi_i = 4'b0000;
        #1;
        chk("after_pop_grant", bus.req_cmd_ready_and_o, 4'b0100);
        cyc();
        chk("refill_outstanding", outstanding, 6);
        chk("refill_cmd_v", bus.io_cmd_v_o, 0);

        // Drain all six responses in issue order
        bus.req_cmd_v_i = 4'b0000;
        bus.io_resp_v_i = 1'b1;
        bus.req_resp_yumi_i = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("resp_route", bus.req_resp_v_o, 32'(1) << exp_h[k]);
            cyc();
        end
        bus.io_resp_v_i = 1'b0;
        bus.req_resp_yumi_i = 4'b0000;
        #1;
        chk("empty_outstanding", outstanding, 0);

        // Issue req2, req0, req2 (rr_ptr starts at 3)
        cyc();
        bus.req_cmd_v_i = 4'b0100;
        #1;
        chk("seq_g2a", bus.req_cmd_ready_and_o, 4'b0100);
        cyc();
        bus.req_cmd_v_i = 4'b0001;
        #1;
        chk("seq_g0", bus.req_cmd_ready_and_o, 4'b0001);
        cyc();
        bus.req_cmd_v_i = 4'b0100;
        #1;
        chk("seq_g2b", bus.req_cmd_ready_and_o, 4'b0100);
        cyc();
        bus.req_cmd_v_i = 4'b0000;
        drain = 1'b1;
        cyc();

        // Draining: no grants, responses still route
        bus.req_cmd_v_i = 4'b1111;
        #1;
        chk("drain_cmd_v", bus.io_cmd_v_o, 0);
        chk("drain_ready", bus.req_cmd_ready_and_o, 0);
        chk("drain_outstanding", outstanding, 3);
        bus.io_resp_v_i = 1'b1;
        bus.req_resp_yumi_i = 4'b1111;
        #1;
        chk("drain_route0", bus.req_resp_v_o, 4'b0100);
        cyc();
        chk("drain_route1", bus.req_resp_v_o, 4'b0001);
        cyc();
        chk("drain_route2", bus.req_resp_v_o, 4'b0100);
        chk("idle_before_last_pop", idle, 0);
        cyc();
        bus.io_resp_v_i = 1'b0;
        bus.req_resp_yumi_i = 4'b0000;
        #1;
        chk("idle_after_last_pop", idle, 1);
        chk("idle_cmd_v", bus.io_cmd_v_o, 0);

        // Release drain: grants resume at rr_ptr=3
        drain = 1'b0;
        cyc();
        chk("resume_idle", idle, 0);
        chk("resume_grant", bus.req_cmd_ready_and_o, 4'b1000);
        cyc();

        // Simultaneous fire and pop at count=1
        bus.req_cmd_v_i = 4'b0001;
        bus.io_resp_v_i = 1'b1;
        bus.req_resp_yumi_i = 4'b1000;
        #1;
        chk("sim_grant", bus.req_cmd_ready_and_o, 4'b0001);
        chk("sim_resp_v", bus.req_resp_v_o, 4'b1000);
        chk("sim_yumi", bus.io_resp_yumi_o, 1);
        cyc();
        chk("sim_outstanding", outstanding, 1);

        // Response held unconsumed for 5 cycles
        bus.req_cmd_v_i = 4'b0000;
        bus.req_resp_yumi_i = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_resp_v", bus.req_resp_v_o, 4'b0001);
            chk("hold_yumi", bus.io_resp_yumi_o, 0);
            cyc();
        end
        chk("hold_outstanding", outstanding, 1);
        bus.req_resp_yumi_i = 4'b0001;
        cyc();
        bus.io_resp_v_i = 1'b0;
        bus.req_resp_yumi_i = 4'b0000;
        #1;
        chk("hold_popped", outstanding, 0);

        // Stalled grant stays put when a nearer requester appears (rr_ptr=1)
        bus.io_cmd_ready_and_i = 1'b0;
        bus.req_cmd_v_i = 4'b1000;
        #1;
        chk("stall_cmd_v", bus.io_cmd_v_o, 1);
        chk("stall_dat", bus.io_cmd_o, 16'hC300);
        chk("stall_ready", bus.req_cmd_ready_and_o, 0);
        cyc();
        bus.req_cmd_v_i = 4'b1010;
        #1;
        chk("stall_hold_dat", bus.io_cmd_o, 16'hC300);
        cyc();
        bus.io_cmd_ready_and_i = 1'b1;
        #1;
        chk("stall_fire_grant", bus.req_cmd_ready_and_o, 4'b1000);
        cyc();

        // Build count=5, then assert reset between edges
        bus.req_cmd_v_i = 4'b1111;
        repeat (4) cyc();
        bus.io_resp_v_i = 1'b1;
        #1;
        chk("burst_outstanding", outstanding, 5);
        chk("burst_resp_v", bus.req_resp_v_o, 4'b1000);
        chk("burst_cmd_v", bus.io_cmd_v_o, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_cmd_v", bus.io_cmd_v_o, 0);
        chk("async_ready", bus.req_cmd_ready_and_o, 0);
        chk("async_resp_v", bus.req_resp_v_o, 0);
        chk("async_outstanding", outstanding, 0);
        bus.io_resp_v_i = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_grant", bus.req_cmd_ready_and_o, 4'b0001);
        chk("post_rst_outstanding", outstanding, 0);
        chk("post_rst_idle", idle, 0);
        cyc();

        // req0 and req3 contend (rr_ptr=1 after the first post-reset fire)
        bus.req_cmd_v_i = 4'b1001;
`ifdef BP_HOST_IO_ARB_FIXED_PRIO_EN
        #1; chk("prio_g0", bus.req_cmd_ready_and_o, 4'b0001); cyc();
        chk("prio_g1", bus.req_cmd_ready_and_o, 4'b0001); cyc();
        chk("prio_g2", bus.req_cmd_ready_and_o, 4'b0001); cyc();
`else
        #1; chk("prio_g0", bus.req_cmd_ready_and_o, 4'b1000); cyc();
        chk("prio_g1", bus.req_cmd_ready_and_o, 4'b0001); cyc();
        chk("prio_g2", bus.req_cmd_ready_and_o, 4'b1000); cyc();
`endif
        bus.req_cmd_v_i = 4'b1000;
        #1;
        chk("prio_req0_drop", bus.req_cmd_ready_and_o, 4'b1000);
        cyc();
        bus.req_cmd_v_i = 4'b0000;
        #1;
        chk("final_outstanding", outstanding, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_host_io_arbiter.md
Name: bp_host_io_arbiter

Overview:
- Shares the single host I/O command/response channel between num_req_p independent requesters, e.g. per-core or per-chip I/O masters.
- Sits between requesters and the nonsynth host device, upstream of the host's cmd/resp ports.
- Round-robin arbitration on commands. Responses return in command order, so an in-order source-tag FIFO routes each response back to its requester.
- Drain/idle sequencing lets the testbench quiesce all host traffic, e.g. before finish or checkpoint.

Parameters:
- num_req_p, 4, number of requesters (>=2).
- msg_width_p, 576, bedrock mem message width (header + data), passed through opaque.
- max_outstanding_p, 32, max commands issued without a response; sizes the tag FIFO. Must be <= host FIFO depth.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- req_cmd_i  in  num_req_p*msg_width_p  per-requester command messages, requester r at slice r
- req_cmd_v_i  in  num_req_p  command valid
- req_cmd_ready_and_o  out  num_req_p  command accepted (ready&valid handshake)
- req_resp_o  out  num_req_p*msg_width_p  response message, broadcast copy of io_resp_i on every slice
- req_resp_v_o  out  num_req_p  response valid, one-hot or zero
- req_resp_yumi_i  in  num_req_p  response consumed
- io_cmd_o  out  msg_width_p  command to host
- io_cmd_v_o  out  1  command valid to host
- io_cmd_ready_and_i  in  1  host ready
- io_resp_i  in  msg_width_p  host response
- io_resp_v_i  in  1  host response valid
- io_resp_yumi_o  out  1  host response consumed
- drain_i  in  1  stop issuing new commands
- idle_o  out  1  drained, zero outstanding
- outstanding_o  out  clog2(max_outstanding_p+1)  current outstanding count

Behaviour:
- Reset (async assert, sync release):
  - state=RUN, rr_ptr=0, count=0, tag FIFO empty, idle_o=0.
  - All *_v_o, ready and yumi outputs are 0 while reset_i is high.
- can_issue = (state==RUN) & (count < max_outstanding_p).
- Grant:
  - Combinational. First valid requester searching from rr_ptr upward, wrapping num_req_p-1 -> 0.
  - Only evaluated when can_issue.
- Command path:
  - Zero latency. io_cmd_o = req_cmd_i[grant]; io_cmd_v_o = can_issue & |req_cmd_v_i.
  - req_cmd_ready_and_o[grant] = can_issue & io_cmd_ready_and_i; all other bits 0.
  - Grant must not change while io_cmd_v_o is high and unaccepted. The command stays stable and valid until it fires.
- On cmd fire (io_cmd_v_o & io_cmd_ready_and_i):
  - Push the grant index into the tag FIFO.
  - rr_ptr <= grant+1, wrapping mod num_req_p.
- Response path:
  - head = tag FIFO head.
  - req_resp_v_o[head] = io_resp_v_i & ~fifo_empty.
  - io_resp_yumi_o = req_resp_yumi_i[head] & req_resp_v_o[head]; pops the tag.
  - A yumi on a non-head bit is ignored.
- count: +1 on cmd fire, -1 on resp pop. Simultaneous fire and pop leaves count unchanged. outstanding_o = count.
- Full: count==max_outstanding_p blocks all grants. A same-cycle pop does not unblock the same cycle; the next grant is the following cycle.
- Response with empty tag FIFO:
  - Protocol error. Do not yumi.
  - Simulation assertion prints "host_io_arbiter: orphan response" and calls $error.
- State machine:
  - RUN: drain_i=1 -> DRAIN.
  - DRAIN:
    - No new grants.
    - Responses still route.
    - count==0 & drain_i -> IDLE.
    - drain_i=0 -> RUN, with rr_ptr preserved.
  - IDLE: idle_o=1; drain_i=0 -> RUN.
  - drain_i rising during a stalled command: the stalled command is withdrawn (valid may drop). Requesters are ready/valid and hold their own data, so nothing is lost.
- Reset mid-operation: all state cleared. In-flight responses arriving after reset are orphans; the bench must reset the host too.

Optional Feature:
- Macro: BP_HOST_IO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. rr_ptr is removed and held at 0.
- Undefined (default): round-robin as above.
- Tag FIFO, drain and response routing are unchanged in both modes.

Test Plan:
- num_req_p=4, all four valid continuously, host always ready -> grant order 0,1,2,3,0,1; responses returned in order go to req_resp_v_o=0001,0010,0100,1000.
- max_outstanding_p=2, host never responds, req0 streams commands -> exactly 2 fires, then io_cmd_v_o=0 and outstanding_o=2. One response popped -> next cycle a new fire; outstanding_o stays 2.
- Issue 3 commands (req2, req0, req2), then drain_i=1 -> no further fires. idle_o rises the cycle after the third response pops. drain_i=0 -> grants resume at rr_ptr=3.
- Simultaneous cmd fire and resp pop at count=1 -> count stays 1. Response held with req_resp_yumi_i low for 5 cycles -> io_resp_yumi_o=0 and tag not popped.
- Assert reset_i asynchronously mid-burst (count=5) -> outputs go 0 immediately without waiting for a clock edge; after release outstanding_o=0, idle_o=0, first grant=req0.
- With BP_HOST_IO_ARB_FIXED_PRIO_EN, req0 and req3 both valid continuously -> req0 wins every cycle and req3 is never granted until req0 drops.
